controle_valvula_nivel: RTL and testbench

CONTROLE_VALVULA_NIVEL -- requirements
Module: controle_valvula_nivel

---
 rtl/controle_valvula_nivel_pkg.sv | 21 ++
 rtl/controle_valvula_nivel_contador_timeout.sv | 36 +++
 rtl/controle_valvula_nivel.sv | 163 ++++++++++++++++
 tb/tb_controle_valvula_nivel.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/controle_valvula_nivel_pkg.sv
// Shared definitions for the tank-level valve controller: state codes,
// parameter defaults and the BCD sanity check used on sensor samples.
package controle_valvula_nivel_pkg;

   localparam int CONFIRMA_PADRAO = 3;
   localparam int TIMEOUT_PADRAO  = 50_000_000;

   typedef enum logic [3:0] {
      OCIOSO  = 4'd0,
      FECHADA = 4'd1,
      ABERTA  = 4'd2,
      CRITICO = 4'd3,
      MANUAL  = 4'd4,
      FALHA   = 4'd5
   } estado_t;

   function automatic logic bcd_valido(input logic [11:0] v);
      return (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

endpackage

// File: rtl/controle_valvula_nivel_contador_timeout.sv
// Watchdog for the sensor strobe: counts cycles since the last clear and
// saturates, holding fim high once the limit is reached.
module contador_timeout
   import controle_valvula_nivel_pkg::*;
#(
   parameter int TIMEOUT_CICLOS = TIMEOUT_PADRAO
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic conta,
   output logic fim
);

   localparam int           W      = $clog2(TIMEOUT_CICLOS + 1);
   localparam logic [W-1:0] LIMITE = W'(TIMEOUT_CICLOS);
   localparam logic [W-1:0] UM     = W'(1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (conta && (cnt_q != LIMITE))
         cnt_d = cnt_q + UM;
   end

   always_ff @(posedge clock) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign fim = (cnt_q == LIMITE);

endmodule

// File: rtl/controle_valvula_nivel.sv
// Tank-level valve controller: confirms BCD distance samples against three
// thresholds, drives the valve and alarms, with manual override and fault state.
module controle_valvula_nivel
   import controle_valvula_nivel_pkg::*;
#(
   parameter int CONFIRMA       = CONFIRMA_PADRAO,
   parameter int TIMEOUT_CICLOS = TIMEOUT_PADRAO
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        medida_pronta,
   input  logic [11:0] distancia,
   input  logic [7:0]  nv_alto,
   input  logic [7:0]  nv_baixo,
   input  logic [7:0]  nv_crit,
   input  logic        manual_en,
   input  logic        manual_abre,
   output logic        abre_valvula,
   output logic        buzzer_alta,
   output logic        buzzer_baixa,
   output logic [3:0]  db_estado,
   output logic        db_abre_auto,
   output logic        db_fecha_auto,
   output logic        db_cfg_invalida
);

   localparam int            CW       = $clog2(CONFIRMA + 1);
   localparam logic [CW-1:0] CONF_MAX = CW'(CONFIRMA);
   localparam logic [CW-1:0] C_UM     = CW'(1);

   estado_t       estado_q, estado_d;
   logic [CW-1:0] conf_a_q, conf_a_d, conf_b_q, conf_b_d;
   logic          alta_q, alta_d;
   logic          cfg_inv_q, cfg_inv_d;
   logic          abre_q, abre_d, buz_alta_q, buz_alta_d, buz_baixa_q, buz_baixa_d;
   logic          p_abre_q, p_abre_d, p_fecha_q, p_fecha_d;
   logic          cond_a, cond_b, fim, falha_entra;
   logic          amostra_valida, amostra_invalida;
   logic [11:0]   alto, baixo, crit;

   assign alto  = {4'h0, nv_alto};
   assign baixo = {4'h0, nv_baixo};
   assign crit  = {4'h0, nv_crit};

   assign amostra_valida   = medida_pronta &  bcd_valido(distancia);
   assign amostra_invalida = medida_pronta & ~bcd_valido(distancia);
   assign cfg_inv_d        = ~((nv_alto < nv_baixo) && (nv_baixo < nv_crit));

   // A sample arriving on the expiry cycle wins over the timeout.
   assign falha_entra = cfg_inv_q | (fim & ~amostra_valida);

   contador_timeout #(.TIMEOUT_CICLOS(TIMEOUT_CICLOS)) u_timeout (
      .clock (clock),
      .reset (reset),
      .clear (amostra_valida | (estado_q == FALHA)),
      .conta (1'b1),
      .fim   (fim)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q    <= OCIOSO;
         conf_a_q    <= '0;
         conf_b_q    <= '0;
         alta_q      <= 1'b0;
         cfg_inv_q   <= 1'b0;
         abre_q      <= 1'b0;
         buz_alta_q  <= 1'b0;
         buz_baixa_q <= 1'b0;
         p_abre_q    <= 1'b0;
         p_fecha_q   <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         conf_a_q    <= conf_a_d;
         conf_b_q    <= conf_b_d;
         alta_q      <= alta_d;
         cfg_inv_q   <= cfg_inv_d;
         abre_q      <= abre_d;
         buz_alta_q  <= buz_alta_d;
         buz_baixa_q <= buz_baixa_d;
         p_abre_q    <= p_abre_d;
         p_fecha_q   <= p_fecha_d;
      end
   end

   // Counter A tracks the state's primary exit condition, B the ABERTA->CRITICO one.
   always_comb begin
      estado_d = estado_q;
      conf_a_d = conf_a_q;
      conf_b_d = conf_b_q;
      cond_a   = 1'b0;
      cond_b   = 1'b0;
      case (estado_q)
         FECHADA: cond_a = (distancia >= baixo);
         ABERTA: begin
            cond_a = (distancia <= alto);
            cond_b = (distancia >= crit);
         end
         CRITICO: cond_a = (distancia < crit);
         default: ;
      endcase

      if (amostra_valida) begin
         conf_a_d = !cond_a ? '0 : (conf_a_q == CONF_MAX) ? conf_a_q : conf_a_q + C_UM;
         conf_b_d = !cond_b ? '0 : (conf_b_q == CONF_MAX) ? conf_b_q : conf_b_q + C_UM;
      end else if (amostra_invalida) begin
         conf_a_d = '0;
         conf_b_d = '0;
      end

      if (falha_entra)
         estado_d = FALHA;
      else if (manual_en && (estado_q != FALHA))
         estado_d = MANUAL;
      else begin
         case (estado_q)
            OCIOSO:
               if (amostra_valida) begin
                  if (distancia >= crit)       estado_d = CRITICO;
                  else if (distancia >= baixo) estado_d = ABERTA;
                  else                         estado_d = FECHADA;
               end
            FECHADA:
               if (amostra_valida && conf_a_d == CONF_MAX) estado_d = ABERTA;
            ABERTA:
               if (amostra_valida && conf_b_d == CONF_MAX)      estado_d = CRITICO;
               else if (amostra_valida && conf_a_d == CONF_MAX) estado_d = FECHADA;
            CRITICO:
               if (amostra_valida && conf_a_d == CONF_MAX) estado_d = ABERTA;
            MANUAL:
               estado_d = OCIOSO;
            FALHA:
               if (amostra_valida) estado_d = OCIOSO;
            default:
               estado_d = OCIOSO;
         endcase
      end

      if (estado_d != estado_q) begin
         conf_a_d = '0;
         conf_b_d = '0;
      end
   end

   always_comb begin
      alta_d      = amostra_valida ? (distancia < alto) : alta_q;
      abre_d      = (estado_d == ABERTA) || (estado_d == CRITICO) ||
                    ((estado_d == MANUAL) && manual_abre);
      buz_baixa_d = (estado_d == CRITICO) || (estado_d == FALHA);
      buz_alta_d  = (estado_d == FALHA) || ((estado_d != OCIOSO) && alta_d);
      p_abre_d    = (estado_q == FECHADA) && (estado_d == ABERTA);
      p_fecha_d   = (estado_q == ABERTA) && (estado_d == FECHADA);
   end

   assign abre_valvula    = abre_q;
   assign buzzer_alta     = buz_alta_q;
   assign buzzer_baixa    = buz_baixa_q;
   assign db_estado       = estado_q;
   assign db_abre_auto    = p_abre_q;
   assign db_fecha_auto   = p_fecha_q;
   assign db_cfg_invalida = cfg_inv_q;

endmodule

// File: tb/tb_controle_valvula_nivel.sv
// Bench for the valve controller: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a decimal-domain reference model.
module tb_controle_valvula_nivel;

   localparam int CONF = 3;
   localparam int TMO  = 100;

   logic        clock = 1'b0;
   logic        reset, medida_pronta, manual_en, manual_abre;
   logic [11:0] distancia;
   logic [7:0]  nv_alto, nv_baixo, nv_crit;
   logic        abre_valvula, buzzer_alta, buzzer_baixa;
   logic [3:0]  db_estado;
   logic        db_abre_auto, db_fecha_auto, db_cfg_invalida;

   int n_tot = 0, n_pass = 0;
   bit chk_en = 0;

   int m_st, m_ca, m_cb, m_idle;
   bit m_flag, m_cfgbad;
   int e_abre, e_alta, e_baixa, e_pa, e_pf;

   always #5 clock = ~clock;

   controle_valvula_nivel #(.CONFIRMA(CONF), .TIMEOUT_CICLOS(TMO)) dut (
      .clock(clock), .reset(reset), .medida_pronta(medida_pronta),
      .distancia(distancia), .nv_alto(nv_alto), .nv_baixo(nv_baixo),
      .nv_crit(nv_crit), .manual_en(manual_en), .manual_abre(manual_abre),
      .abre_valvula(abre_valvula), .buzzer_alta(buzzer_alta),
      .buzzer_baixa(buzzer_baixa), .db_estado(db_estado),
      .db_abre_auto(db_abre_auto), .db_fecha_auto(db_fecha_auto),
      .db_cfg_invalida(db_cfg_invalida)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
   endtask

   function automatic bit digitos_ok(input logic [11:0] v);
      return (v[11:8] < 10) && (v[7:4] < 10) && (v[3:0] < 10);
   endfunction

   function automatic int dec(input logic [11:0] v);
      return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic int sat(input int v);
      return (v > CONF) ? CONF : v;
   endfunction

   // Reference: thresholds and distance compared as decimal centimetres.
   task automatic model_step();
      bit valid;
      int prev, nxt, d, a, b, c;
      if (reset) begin
         m_st = 0; m_ca = 0; m_cb = 0; m_idle = 0; m_flag = 0; m_cfgbad = 0;
         e_abre = 0; e_alta = 0; e_baixa = 0; e_pa = 0; e_pf = 0;
         return;
      end
      valid = medida_pronta && digitos_ok(distancia);
      d = dec(distancia);
      a = dec({4'h0, nv_alto}); b = dec({4'h0, nv_baixo}); c = dec({4'h0, nv_crit});
      prev = m_st;
      if (valid) begin
         case (prev)
            1: begin m_ca = (d >= b) ? sat(m_ca + 1) : 0; m_cb = 0; end
            2: begin m_ca = (d <= a) ? sat(m_ca + 1) : 0; m_cb = (d >= c) ? sat(m_cb + 1) : 0; end
            3: begin m_ca = (d < c) ? sat(m_ca + 1) : 0; m_cb = 0; end
            default: begin m_ca = 0; m_cb = 0; end
         endcase
      end else if (medida_pronta) begin
         m_ca = 0; m_cb = 0;
      end
      nxt = prev;
      if (m_cfgbad || (m_idle >= TMO && !valid)) nxt = 5;
      else if (manual_en && prev != 5) nxt = 4;
      else begin
         case (prev)
            0: if (valid) nxt = (d >= c) ? 3 : (d >= b) ? 2 : 1;
            1: if (valid && m_ca == CONF) nxt = 2;
            2: if (valid && m_cb == CONF) nxt = 3; else if (valid && m_ca == CONF) nxt = 1;
            3: if (valid && m_ca == CONF) nxt = 2;
            4: nxt = 0;
            5: if (valid) nxt = 0;
            default: nxt = 0;
         endcase
      end
      if (nxt != prev) begin m_ca = 0; m_cb = 0; end
      m_idle = valid ? 0 : ((m_idle > TMO) ? m_idle : m_idle + 1);
      if (valid) m_flag = (d < a);
      m_cfgbad = !((a < b) && (b < c));
      e_abre  = (nxt == 2 || nxt == 3 || (nxt == 4 && manual_abre)) ? 1 : 0;
      e_baixa = (nxt == 3 || nxt == 5) ? 1 : 0;
      e_alta  = (nxt == 5) ? 1 : (nxt == 0) ? 0 : int'(m_flag);
      e_pa    = (prev == 1 && nxt == 2) ? 1 : 0;
      e_pf    = (prev == 2 && nxt == 1) ? 1 : 0;
      m_st    = nxt;
   endtask

   always @(negedge clock) begin
      if (chk_en) begin
         chk("estado", int'(db_estado), m_st);
         chk("abre_valvula", int'(abre_valvula), e_abre);
         chk("buzzer_alta", int'(buzzer_alta), e_alta);
         chk("buzzer_baixa", int'(buzzer_baixa), e_baixa);
         chk("db_abre_auto", int'(db_abre_auto), e_pa);
         chk("db_fecha_auto", int'(db_fecha_auto), e_pf);
         chk("db_cfg_invalida", int'(db_cfg_invalida), int'(m_cfgbad));
      end
   end

   task automatic cyc(input logic mp, input logic [11:0] d);
      medida_pronta = mp;
      distancia     = d;
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic samp(input logic [11:0] d);
      cyc(1'b1, d);
   endtask

   task automatic ociosos(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 12'h000);
   endtask

   // Pins both DUT and model to a hand-derived value.
   task automatic lit(input string nm, input int dut_v, input int mdl_v, input int exp);
      chk(nm, dut_v, exp);
      chk({nm, "_model"}, mdl_v, exp);
   endtask

   initial begin
      reset = 1'b1; medida_pronta = 1'b0; distancia = '0;
      manual_en = 1'b0; manual_abre = 1'b0;
      nv_alto = 8'h20; nv_baixo = 8'h50; nv_crit = 8'h80;
      cyc(1'b0, 12'h000);
      chk_en = 1;
      cyc(1'b0, 12'h000);
      lit("rst_estado", int'(db_estado), m_st, 0);
      lit("rst_abre", int'(abre_valvula), e_abre, 0);
      lit("rst_buzzers", int'(buzzer_alta) + int'(buzzer_baixa), e_alta + e_baixa, 0);
      reset = 1'b0;

      samp(12'h035);
      lit("first_fechada", int'(db_estado), m_st, 1);
      lit("first_abre", int'(abre_valvula), e_abre, 0);

      samp(12'h060); ociosos(1); samp(12'h060); ociosos(1);
      samp(12'h045); ociosos(1);
      samp(12'h060); samp(12'h060);
      lit("confirm_pending", int'(db_estado), m_st, 1);
      samp(12'h060);
      lit("open_estado", int'(db_estado), m_st, 2);
      lit("open_pulse", int'(db_abre_auto), e_pa, 1);
      ociosos(1);
      lit("open_pulse_end", int'(db_abre_auto), e_pa, 0);

      samp(12'h085); samp(12'h085); samp(12'h085);
      lit("crit_estado", int'(db_estado), m_st, 3);
      lit("crit_baixa", int'(buzzer_baixa), e_baixa, 1);
      samp(12'h070); samp(12'h070); samp(12'h070);
      lit("crit_exit", int'(db_estado), m_st, 2);
      lit("crit_exit_baixa", int'(buzzer_baixa), e_baixa, 0);

      samp(12'h015); samp(12'h015); samp(12'h015);
      lit("close_estado", int'(db_estado), m_st, 1);
      lit("close_pulse", int'(db_fecha_auto), e_pf, 1);
      lit("close_alta", int'(buzzer_alta), e_alta, 1);

      ociosos(100);
      lit("tmo_edge_before", int'(db_estado), m_st, 1);
      ociosos(1);
      lit("tmo_falha", int'(db_estado), m_st, 5);
      lit("tmo_abre", int'(abre_valvula), e_abre, 0);
      lit("tmo_buzzers", int'(buzzer_alta) + int'(buzzer_baixa), e_alta + e_baixa, 2);
      samp(12'h040);
      lit("falha_exit", int'(db_estado), m_st, 0);

      samp(12'h035);
      samp(12'h060); samp(12'h060); samp(12'h0A5); samp(12'h060); samp(12'h060);
      lit("bad_bcd_clears", int'(db_estado), m_st, 1);
      samp(12'h060);
      lit("bad_bcd_then_open", int'(db_estado), m_st, 2);

      manual_en = 1'b1; manual_abre = 1'b1;
      ociosos(1);
      lit("manual_estado", int'(db_estado), m_st, 4);
      lit("manual_abre", int'(abre_valvula), e_abre, 1);
      manual_en = 1'b0; manual_abre = 1'b0;
      ociosos(1);
      lit("manual_exit", int'(db_estado), m_st, 0);

      nv_baixo = 8'h10;
      ociosos(1);
      lit("cfg_flag", int'(db_cfg_invalida), int'(m_cfgbad), 1);
      ociosos(1);
      lit("cfg_falha", int'(db_estado), m_st, 5);
      nv_baixo = 8'h50;
      ociosos(1);
      samp(12'h035);
      lit("cfg_recover", int'(db_estado), m_st, 0);

      ociosos(100);
      samp(12'h035);
      lit("tmo_vs_sample", int'(db_estado), m_st, 1);

      for (int k = 0; k < 4000; k++) begin
         logic [11:0] d;
         if ($urandom_range(0, 59) == 0) manual_en = ~manual_en;
         manual_abre = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 399) == 0) nv_baixo = (nv_baixo == 8'h50) ? 8'h10 : 8'h50;
         if ($urandom_range(0, 299) == 0) ociosos(110);
         if ($urandom_range(0, 15) == 0) d = 12'($urandom_range(0, 4095));
         else d = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         cyc(1'($urandom_range(0, 2) == 0), d);
      end

      reset = 1'b1;
      samp(12'h060);
      lit("final_reset", int'(db_estado), m_st, 0);

      @(posedge clock);
      chk_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
